mem_port_arbiter: RTL

//   Shares one single-port synchronous memory (unified inst/data RAM) between the

---
 rtl/mem_port_arbiter_pkg.sv | 12 +
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared bus widths and constants for the unified-RAM port arbiter.
package mem_port_arbiter_pkg;

  // Bus widths shared with the core (instruction address, instruction and data buses)
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int DataBus     = 32;

  // Byte-enable pattern used for every read access
  localparam logic [3:0] SEL_ALL = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch (IF)
// and load/store (MEM). One access in flight; MEM has priority, and a starvation
// counter forces an IF grant after STARVE_MAX consecutive MEM grants with IF waiting.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = InstAddrBus,
  parameter int DATA_W      = DataBus,
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_gnt_o,
  output logic              mem_rvalid_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_stall_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int LAT_W    = $clog2(MEM_LATENCY) + 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0]    LAT_INIT     = LAT_W'(MEM_LATENCY - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_MEM  = 2'd2;

  logic                state_r, state_n;
  logic [1:0]          owner_r;
  logic                owner_we_r;
  logic [LAT_W-1:0]    lat_cnt_r;
  logic [STARVE_W-1:0] starve_cnt_r;

  logic       complete_s;
  logic       can_issue_s;
  logic       issue_s;
  logic [1:0] winner_s;

  // Outputs are forced low while rst is held, even though the FSM would otherwise issue.
  assign complete_s  = !rst && (state_r == ST_BUSY) && (lat_cnt_r == '0);
  assign can_issue_s = !rst && ((state_r == ST_IDLE) || complete_s);
  assign issue_s     = (winner_s != OWN_NONE);

  // Pick the requester to issue this cycle (MEM first unless IF has been starved)
  always_comb begin
    winner_s = OWN_NONE;
    if (can_issue_s) begin
      if (mem_req_i && if_req_i) begin
        winner_s = (starve_cnt_r == STARVE_LIMIT) ? OWN_IF : OWN_MEM;
      end else if (mem_req_i) begin
        winner_s = OWN_MEM;
      end else if (if_req_i) begin
        winner_s = OWN_IF;
      end else begin
        winner_s = OWN_NONE;
      end
    end else begin
      winner_s = OWN_NONE;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next state: an issue always lands in BUSY; a completion without a new issue returns to IDLE
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: state_n = issue_s ? ST_BUSY : ST_IDLE;
      ST_BUSY: begin
        if (lat_cnt_r == '0) begin
          state_n = issue_s ? ST_BUSY : ST_IDLE;
        end else begin
          state_n = ST_BUSY;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Track owner of the in-flight access, its latency countdown and IF starvation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r      <= OWN_NONE;
      owner_we_r   <= 1'b0;
      lat_cnt_r    <= '0;
      starve_cnt_r <= '0;
    end else begin
      if (issue_s) begin
        owner_r    <= winner_s;
        owner_we_r <= (winner_s == OWN_MEM) && mem_we_i;
        lat_cnt_r  <= LAT_INIT;
      end else if ((state_r == ST_BUSY) && (lat_cnt_r != '0)) begin
        lat_cnt_r <= lat_cnt_r - LAT_W'(1);
      end else if (complete_s) begin
        owner_r    <= OWN_NONE;
        owner_we_r <= 1'b0;
      end

      if (winner_s == OWN_IF) begin
        starve_cnt_r <= '0;
      end else if ((winner_s == OWN_MEM) && if_req_i && (starve_cnt_r != STARVE_LIMIT)) begin
        starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
      end
    end
  end

  // Drive grants, the RAM request and the per-port completion/stall outputs
  always_comb begin
    if_gnt_o     = 1'b0;
    mem_gnt_o    = 1'b0;
    ram_ce_o     = 1'b0;
    ram_we_o     = 1'b0;
    ram_addr_o   = '0;
    ram_sel_o    = 4'b0000;
    ram_wdata_o  = '0;
    if_rvalid_o  = 1'b0;
    if_rdata_o   = '0;
    mem_rvalid_o = 1'b0;
    mem_rdata_o  = '0;

    case (winner_s)
      OWN_IF: begin
        if_gnt_o   = 1'b1;
        ram_ce_o   = 1'b1;
        ram_addr_o = if_addr_i;
        ram_sel_o  = SEL_ALL;
      end
      OWN_MEM: begin
        mem_gnt_o   = 1'b1;
        ram_ce_o    = 1'b1;
        ram_we_o    = mem_we_i;
        ram_addr_o  = mem_addr_i;
        ram_sel_o   = mem_we_i ? mem_sel_i : SEL_ALL;
        ram_wdata_o = mem_wdata_i;
      end
      default: begin
        ram_ce_o = 1'b0;
      end
    endcase

    if (complete_s) begin
      case (owner_r)
        OWN_IF: begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = ram_rdata_i;
        end
        OWN_MEM: begin
          mem_rvalid_o = 1'b1;
          mem_rdata_o  = owner_we_r ? '0 : ram_rdata_i;
        end
        default: begin
          if_rvalid_o = 1'b0;
        end
      endcase
    end else begin
      mem_rvalid_o = 1'b0;
    end

    if_stall_o  = !rst && if_req_i && !if_rvalid_o;
    mem_stall_o = !rst && mem_req_i && !mem_rvalid_o;
  end

endmodule
